// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module      : alu_sequencer_if
// Description : Instruction handshake, ALU bus, writeback status and debug port
//               bundle for alu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] alu_operand1;
  logic [DATA_W-1:0] alu_operand2;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] result;
  logic              done;
  logic              illegal;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, instr, alu_result, dbg_addr,
    input  instr_ready, alu_operand1, alu_operand2, alu_opcode,
           result, done, illegal, dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_result, dbg_addr,
    output instr_ready, alu_operand1, alu_operand2, alu_opcode,
           result, done, illegal, dbg_data
  );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Serialized issue/writeback stage around a combinational ALU
//               with an 8 x 32 register file (r0 reads zero). Defining
//               ALU_SEQ_DEBUG_EN enables the debug register-read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_sequencer_if.slave   bus_io
);
  localparam int NREG = 1 << REG_AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] op1_q, op2_q, result_q;
  logic [3:0]        opc_q;
  logic [REG_AW-1:0] rd_q;

  logic [3:0]        w_op;
  logic              w_imm_f;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_sext, w_rs1_val, w_rs2_val, w_op2;
  logic              w_accept, w_legal;
  logic              w_unused;

  assign w_op    = bus_io.instr[31:28];
  assign w_imm_f = bus_io.instr[27];
  assign w_rd    = bus_io.instr[24 +: REG_AW];
  assign w_rs1   = bus_io.instr[21 +: REG_AW];
  assign w_rs2   = bus_io.instr[18 +: REG_AW];
  assign w_sext  = {{(DATA_W-16){bus_io.instr[15]}}, bus_io.instr[15:0]};
  assign w_unused = ^bus_io.instr[17:16];

  assign w_rs1_val = (w_rs1 == '0) ? '0 : rf_q[w_rs1];
  assign w_rs2_val = (w_rs2 == '0) ? '0 : rf_q[w_rs2];
  assign w_op2     = w_imm_f ? w_sext : w_rs2_val;

  // Codes the ALU does not implement must never reach it: it would hold its old result.
  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0110, 4'b0111, 4'b1000, 4'b1001: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  assign bus_io.instr_ready = (state_q == S_IDLE) & ~rst;
  assign w_accept           = bus_io.instr_valid & bus_io.instr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = w_legal ? S_EXEC : S_ERR;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      opc_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept && w_legal) begin
        opc_q <= w_op;
        op1_q <= w_rs1_val;
        op2_q <= w_op2;
        rd_q  <= w_rd;
      end
      if (state_q == S_EXEC) begin
        result_q <= bus_io.alu_result;
        if (rd_q != '0) rf_q[rd_q] <= bus_io.alu_result;
      end
    end
  end

  assign bus_io.alu_operand1 = op1_q;
  assign bus_io.alu_operand2 = op2_q;
  assign bus_io.alu_opcode   = opc_q;
  assign bus_io.result       = result_q;
  assign bus_io.done         = (state_q == S_WB);
  assign bus_io.illegal      = (state_q == S_ERR);

`ifdef ALU_SEQ_DEBUG_EN
  logic w_dbg_unused;
  assign w_dbg_unused    = 1'b0;
  assign bus_io.dbg_data = (bus_io.dbg_addr == '0) ? '0 : rf_q[bus_io.dbg_addr];
`else
  logic w_dbg_unused;
  assign w_dbg_unused    = ^bus_io.dbg_addr;
  assign bus_io.dbg_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with an ALU stub and a
//               register-file reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(32), .REG_AW(3)) bus_if ();

  alu_sequencer #(.DATA_W(32), .REG_AW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if.slave)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return p[31:0];
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return (b >= 32) ? 32'd0 : (a >> b[4:0]);
      4'd9:    return (b >= 32) ? 32'd0 : (a << b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb bus_if.alu_result = alu_fn(bus_if.alu_opcode, bus_if.alu_operand1,
                                         bus_if.alu_operand2);

  logic [31:0] rf_m [8];
  logic [31:0] last_a, last_b, exp_res;
  logic [3:0]  last_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input int idx);
    logic [31:0] e;
    bus_if.dbg_addr = 3'(idx);
    #1;
`ifdef ALU_SEQ_DEBUG_EN
    e = (idx == 0) ? 32'd0 : rf_m[idx];
`else
    e = 32'd0;
`endif
    chk($sformatf("dbg_r%0d", idx), bus_if.dbg_data, e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = 32'd0;
    last_a = 0; last_b = 0; last_op = 0; exp_res = 0;
  endtask

  // Issues one instruction at the first edge and follows it back to IDLE.
  task automatic issue(input logic [31:0] ins);
    logic [3:0]  op;
    logic        legal;
    int          rd, rs1, rs2;
    logic [31:0] a, b, e, sx;
    op  = ins[31:28];
    rd  = int'(ins[26:24]);
    rs1 = int'(ins[23:21]);
    rs2 = int'(ins[20:18]);
    sx  = {{16{ins[15]}}, ins[15:0]};
    legal = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
    a = (rs1 == 0) ? 32'd0 : rf_m[rs1];
    b = ins[27] ? sx : ((rs2 == 0) ? 32'd0 : rf_m[rs2]);

    chk("ready_idle", 32'(bus_if.instr_ready), 32'd1);
    bus_if.instr_valid = 1'b1;
    bus_if.instr       = ins;
    @(posedge clk); #1;
    bus_if.instr_valid = 1'b0;
    bus_if.instr       = $urandom;
    chk("ready_busy", 32'(bus_if.instr_ready), 32'd0);
    if (legal) begin
      last_op = op; last_a = a; last_b = b;
      chk("exec_opcode", 32'(bus_if.alu_opcode), 32'(op));
      chk("exec_op1", bus_if.alu_operand1, a);
      chk("exec_op2", bus_if.alu_operand2, b);
      chk("exec_done", 32'(bus_if.done), 32'd0);
      e = alu_fn(op, a, b);
      @(posedge clk); #1;
      if (rd != 0) rf_m[rd] = e;
      exp_res = e;
      chk("wb_done", 32'(bus_if.done), 32'd1);
      chk("wb_result", bus_if.result, e);
      chk_reg(rd);
      @(posedge clk); #1;
      chk("post_done", 32'(bus_if.done), 32'd0);
    end else begin
      chk("err_illegal", 32'(bus_if.illegal), 32'd1);
      chk("err_done", 32'(bus_if.done), 32'd0);
      chk("err_opcode", 32'(bus_if.alu_opcode), 32'(last_op));
      chk("err_op1", bus_if.alu_operand1, last_a);
      chk("err_op2", bus_if.alu_operand2, last_b);
      @(posedge clk); #1;
      chk("err_clear", 32'(bus_if.illegal), 32'd0);
      chk("err_ready", 32'(bus_if.instr_ready), 32'd1);
      chk("err_result", bus_if.result, exp_res);
      chk_reg(rd);
    end
  endtask

  initial begin
    logic [31:0] ins;
    bus_if.instr_valid = 1'b0;
    bus_if.instr       = 32'd0;
    bus_if.dbg_addr    = 3'd0;
    model_reset();

    #12;
    chk("rst_ready", 32'(bus_if.instr_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_illegal", 32'(bus_if.illegal), 32'd0);
    chk("rst_result", bus_if.result, 32'd0);
    for (int i = 0; i < 8; i++) chk_reg(i);

    issue(32'h0900_0019);
    issue(32'h2224_0000);
    issue(32'h1B20_FFFD);
    issue(32'h5400_0000);
    issue(32'h0800_0019);
    issue(32'h9D20_0028);

    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      if (n % 4 == 0) ins[31:28] = 4'(($urandom_range(0, 1) != 0) ? 8 : 9);
      issue(ins);
    end
    for (int i = 0; i < 8; i++) chk_reg(i);

    // Abort an instruction mid-flight.
    bus_if.instr_valid = 1'b1;
    bus_if.instr       = 32'h0900_0077;
    @(posedge clk); #1;
    bus_if.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("abort_ready", 32'(bus_if.instr_ready), 32'd0);
    chk("abort_done", 32'(bus_if.done), 32'd0);
    chk("abort_opcode", 32'(bus_if.alu_opcode), 32'd0);
    chk("abort_op1", bus_if.alu_operand1, 32'd0);
    chk("abort_op2", bus_if.alu_operand2, 32'd0);
    chk("abort_result", bus_if.result, 32'd0);
    @(posedge clk); #1;
    chk("abort_done2", 32'(bus_if.done), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_ready", 32'(bus_if.instr_ready), 32'd1);
    for (int i = 0; i < 8; i++) chk_reg(i);
    @(posedge clk); #1;
    chk("release_done", 32'(bus_if.done), 32'd0);
    chk("release_illegal", 32'(bus_if.illegal), 32'd0);
    issue(32'h0900_0019);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Issue/writeback stage wrapped around the combinational ALU. Accepts one 32-bit instruction per valid/ready handshake, reads operands from an internal 8 x 32 register file, and drives registered `operand1`/`operand2`/`opcode` to the ALU. It then captures the ALU `result` back into the destination register and pulses `done`. Instructions are fully serialized, one in flight at a time, so no hazard logic is needed.

## Interface
- `DATA_W`, 32, datapath width; must match the ALU.
- `REG_AW`, 3, register address width; gives 2^REG_AW registers, with r0 hardwired to zero.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  stage can accept an instruction.
- `instr`  in  32  instruction word, format below.
- `alu_operand1`  out  DATA_W  to ALU `operand1`.
- `alu_operand2`  out  DATA_W  to ALU `operand2`.
- `alu_opcode`  out  4  to ALU `opcode`.
- `alu_result`  in  DATA_W  from ALU `result`, combinational.
- `result`  out  DATA_W  last written-back value.
- `done`  out  1  one-cycle pulse; the writeback has completed.
- `illegal`  out  1  one-cycle pulse; an opcode was rejected.
- `dbg_addr`  in  REG_AW  debug register-read address.
- `dbg_data`  out  DATA_W  debug register-read data.

## Operation
- Instruction format:
  - [31:28] opcode
  - [27] imm flag
  - [26:24] rd
  - [23:21] rs1
  - [20:18] rs2
  - [15:0] imm, sign-extended to DATA_W
  - [17:16] reserved, ignored
- Legal opcodes: 0000 add, 0001 sub, 0010 mul (low 32 bits kept), 0011 and, 0100 or, 0110 xor, 0111 not, 1000 srl, 1001 sll.
- Illegal opcodes: 0101 and 1010–1111 are rejected. They are never presented to the ALU, because the ALU holds its previous result on those codes.
- Operand selection: operand1 = reg[rs1]. Operand2 = sext(imm) when the imm flag is 1, else reg[rs2]. Reading r0 returns 0.
- Shifts use the full operand2 value; an amount of 32 or more yields 0.
- FSM states and transitions:
  - IDLE: `instr_ready`=1. On valid&ready, decode the opcode.
    - Legal: latch opcode and operands into the `alu_*` registers, latch rd, go to EXEC.
    - Illegal: go to ERR; the `alu_*` registers keep their old values.
  - EXEC: the ALU settles. On the clock edge, write `alu_result` to reg[rd] (discarded if rd=0), load `result`, go to WB.
  - WB: `done`=1, then go to IDLE.
  - ERR: `illegal`=1, then go to IDLE. No register or `result` change.
- `instr_ready` = (state==IDLE) & ~rst.
- The `instr` input is ignored when not accepted.
- Reset (at any time, including mid-instruction):
  - State goes to IDLE immediately; an in-flight instruction is aborted with no writeback, no `done` and no `illegal`.
  - All registers, `alu_operand1`, `alu_operand2`, `alu_opcode`, `result`, `done`, `illegal` and `dbg_data` are 0.

## Timing
- Let the accept be edge A, the edge where valid&ready is high.
- Cycle after A: EXEC, with stable `alu_*` outputs.
- Edge A+1: writeback.
- Cycle after A+1: `done`=1 and `result` valid.
- Edge A+2: back to IDLE; the earliest next accept is edge A+3.
- Throughput: one instruction per 3 cycles.
- Illegal instruction: `illegal`=1 in the cycle after A; the earliest next accept is edge A+2.
- `result` holds its value until the next writeback.
- `dbg_data` is combinational from the register file. A read of rd in the WB cycle returns the new value.

## Configuration
- `ALU_SEQ_DEBUG_EN`: when defined, the debug read port is live: `dbg_data` = reg[`dbg_addr`], and r0 reads 0.
- When undefined: `dbg_data` is tied to 0 and `dbg_addr` is ignored. Functional behaviour is otherwise identical.
- The bench below requires the macro to be defined.

## Test plan
- Reset, then release -> `instr_ready`=1, `dbg_data`=0 for all addresses, `done`=`illegal`=0.
- Accept 0x09000019 (r1 = r0 + 25) -> `alu_opcode`=0000 and operands 0/25 in EXEC; `done` high in the cycle after A+1; `result`=25; r1=25.
- Then 0x22240000 (r2 = r1\*r1) -> r2=625. Then 0x1B20FFFD (r3 = r1 − (−3)) -> r3=28.
- Accept opcode 0101 with rd=4 -> `illegal` pulses one cycle, `done` stays 0, r4 unchanged, `alu_*` outputs unchanged, `instr_ready` back at edge A+1.
- Write 25 to rd=0 -> r0 reads 0. Then sll r1 by imm 40 into r5 -> r5=0.
- Assert `rst` during EXEC -> no `done`, all registers 0, `instr_ready` low while `rst` is high and 1 after release.
